// File: rtl/prev_frame_store.sv
// prev_frame_store
// Keeps a spatially decimated copy of the last complete frame. On every
// decimated (sampled) pixel of the current frame, it reads the word stored
// at that location by the previous frame and overwrites it with the new
// pixel in the same cycle. The old and new values then appear together,
// one cycle later.
//
// Ports
//   i_clk         single clock, rising edge
//   i_reset       synchronous active-high reset
//   i_sof         start of frame, qualified by i_pix_valid, marks pixel (0,0)
//   i_pix_valid   i_pix_data valid this cycle
//   i_pix_data    current-frame RAW pixel, raster order
//   o_prev_valid  o_prev_data/o_cur_data valid (sampled pixel, predecessor stored)
//   o_prev_data   same-location pixel from the previous complete frame
//   o_cur_data    current pixel aligned with o_prev_data
//   o_frame_done  one-cycle pulse after the last pixel of a frame is accepted
//   o_sync_err    one-cycle pulse when sof arrives while a frame is in progress
module prev_frame_store #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned DECIM    = 4,
  parameter int unsigned DATA_W   = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_sof,
  input  logic              i_pix_valid,
  input  logic [DATA_W-1:0] i_pix_data,
  output logic              o_prev_valid,
  output logic [DATA_W-1:0] o_prev_data,
  output logic [DATA_W-1:0] o_cur_data,
  output logic              o_frame_done,
  output logic              o_sync_err
);

  localparam int unsigned H_DEC  = H_ACTIVE / DECIM;
  localparam int unsigned V_DEC  = V_ACTIVE / DECIM;
  localparam int unsigned DEPTH  = H_DEC * V_DEC;
  localparam int unsigned X_W    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned Y_W    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SHIFT  = $clog2(DECIM);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [X_W-1:0]    r_x, w_x_next, w_cx;
  logic [Y_W-1:0]    r_y, w_y_next, w_cy;
  logic              r_frame_stored, w_frame_stored_next;
  logic              w_start, w_abort, w_accept, w_last, w_sample, w_stored_eff;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_old;

  logic              r_prev_valid, r_sync_err;
  logic [DATA_W-1:0] r_prev_data, r_cur_data;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_comb begin
    w_state_next        = r_state;
    w_x_next            = r_x;
    w_y_next            = r_y;
    w_frame_stored_next = r_frame_stored;
    w_accept            = 1'b0;
    w_abort             = 1'b0;
    w_start             = i_pix_valid & i_sof;
    // Coordinates of the pixel on the bus: sof always restarts at (0,0).
    w_cx                = w_start ? '0 : r_x;
    w_cy                = w_start ? '0 : r_y;

    unique case (r_state)
      StIdle, StDone: w_accept = w_start;
      StActive: begin
        w_accept = i_pix_valid;
        w_abort  = w_start;
      end
      default: ;
    endcase

    if (w_abort) w_frame_stored_next = 1'b0;

    w_last = (w_cx == X_W'(H_ACTIVE - 1)) && (w_cy == Y_W'(V_ACTIVE - 1));

    if (w_accept) begin
      if (w_last) begin
        w_state_next        = StDone;
        w_x_next            = '0;
        w_y_next            = '0;
        w_frame_stored_next = 1'b1;
      end else begin
        w_state_next = StActive;
        if (w_cx == X_W'(H_ACTIVE - 1)) begin
          w_x_next = '0;
          w_y_next = w_cy + Y_W'(1);
        end else begin
          w_x_next = w_cx + X_W'(1);
          w_y_next = w_cy;
        end
      end
    end else if (r_state == StDone) begin
      w_state_next = StIdle;
    end

    w_sample = w_accept && ((w_cx & X_W'(DECIM - 1)) == '0) &&
               ((w_cy & Y_W'(DECIM - 1)) == '0);
    // An aborting pixel already belongs to a frame with no valid predecessor.
    w_stored_eff = r_frame_stored & ~w_abort;
    w_addr = ADDR_W'(32'(w_cy >> SHIFT) * H_DEC + 32'(w_cx >> SHIFT));
    w_old  = r_mem[w_addr];
  end

  // Storage has no reset; writes are blocked while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (w_sample && !i_reset) r_mem[w_addr] <= i_pix_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_x            <= '0;
      r_y            <= '0;
      r_frame_stored <= 1'b0;
      r_prev_valid   <= 1'b0;
      r_sync_err     <= 1'b0;
      r_prev_data    <= '0;
      r_cur_data     <= '0;
    end else begin
      r_state        <= w_state_next;
      r_x            <= w_x_next;
      r_y            <= w_y_next;
      r_frame_stored <= w_frame_stored_next;
      r_prev_valid   <= w_sample & w_stored_eff;
      r_sync_err     <= w_abort;
      if (w_sample && w_stored_eff) begin
        r_prev_data <= w_old;
        r_cur_data  <= i_pix_data;
      end
    end
  end

  assign o_prev_valid = r_prev_valid;
  assign o_prev_data  = r_prev_data;
  assign o_cur_data   = r_cur_data;
  assign o_frame_done = (r_state == StDone);
  assign o_sync_err   = r_sync_err;

endmodule

// File: tb/tb_prev_frame_store.sv
// Bench for prev_frame_store at 8x4 pixels, decimation 2. A frame-level
// model (pixel index, stored flag, decimated image array) predicts every
// output each cycle; directed frame sequences cover the boundary cases.
module tb_prev_frame_store;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
  localparam int unsigned D = 2;
  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         i_reset = 1'b0, i_sof = 1'b0, i_pix_valid = 1'b0;
  logic [W-1:0] i_pix_data = '0;
  logic         o_prev_valid, o_frame_done, o_sync_err;
  logic [W-1:0] o_prev_data, o_cur_data;

  prev_frame_store #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .DECIM   (D),
    .DATA_W  (W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_sof       (i_sof),
    .i_pix_valid (i_pix_valid),
    .i_pix_data  (i_pix_data),
    .o_prev_valid(o_prev_valid),
    .o_prev_data (o_prev_data),
    .o_cur_data  (o_cur_data),
    .o_frame_done(o_frame_done),
    .o_sync_err  (o_sync_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pv_cnt = 0;

  // Model of the frame store.
  bit           m_in_frame = 1'b0;
  bit           m_stored = 1'b0;
  int           m_p = 0;
  logic [W-1:0] m_img [(H/D)*(V/D)];
  logic [W-1:0] m_prev = '0;
  logic [W-1:0] m_cur = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit s, input logic [W-1:0] d);
    bit e_pv = 1'b0, e_done = 1'b0, e_sync = 1'b0;
    int x, y;
    i_reset = rst; i_pix_valid = v; i_sof = s; i_pix_data = d;
    if (rst) begin
      m_in_frame = 1'b0; m_stored = 1'b0; m_prev = '0; m_cur = '0;
    end else if (v && (s || m_in_frame)) begin
      if (s) begin
        if (m_in_frame) begin
          e_sync = 1'b1;
          m_stored = 1'b0;
        end
        m_p = 0;
        m_in_frame = 1'b1;
      end
      x = m_p % H;
      y = m_p / H;
      if (x % D == 0 && y % D == 0) begin
        if (m_stored) begin
          e_pv = 1'b1;
          m_prev = m_img[(y / D) * (H / D) + x / D];
          m_cur = d;
        end
        m_img[(y / D) * (H / D) + x / D] = d;
      end
      m_p++;
      if (m_p == H * V) begin
        m_in_frame = 1'b0;
        m_stored = 1'b1;
        e_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (o_prev_valid === 1'b1) pv_cnt++;
    chk("prev_valid", 32'(o_prev_valid), 32'(e_pv));
    chk("frame_done", 32'(o_frame_done), 32'(e_done));
    chk("sync_err", 32'(o_sync_err), 32'(e_sync));
    chk("prev_data", 32'(o_prev_data), 32'(m_prev));
    chk("cur_data", 32'(o_cur_data), 32'(m_cur));
  endtask

  // mode 0: x+8y, 1: 100+x+8y, 2: random. gaps inserts an idle cycle before each pixel.
  task automatic send_frame(input int n, input int mode, input bit gaps);
    logic [W-1:0] d;
    for (int i = 0; i < n; i++) begin
      if (gaps) step(1'b0, 1'b0, 1'b0, W'($urandom));
      case (mode)
        0:       d = W'(i);
        1:       d = W'(100 + i);
        default: d = W'($urandom);
      endcase
      step(1'b0, 1'b1, i == 0, d);
    end
  endtask

  int c0;

  initial begin
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 10'h3ff);
    step(1'b0, 1'b1, 1'b0, 10'h155);  // valid without sof in IDLE is ignored

    c0 = pv_cnt; send_frame(32, 0, 1'b0); chk("f1_pv_count", 32'(pv_cnt - c0), 32'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 10'h2aa);
    c0 = pv_cnt; send_frame(32, 1, 1'b0); chk("f2_pv_count", 32'(pv_cnt - c0), 32'd8);
    c0 = pv_cnt; send_frame(32, 2, 1'b1); chk("f2b_gap_pv_count", 32'(pv_cnt - c0), 32'd8);

    // Abort at pixel 10, then complete the restarted frame.
    send_frame(10, 2, 1'b0);
    c0 = pv_cnt; send_frame(32, 2, 1'b0); chk("f3_restart_pv_count", 32'(pv_cnt - c0), 32'd0);
    c0 = pv_cnt; send_frame(32, 2, 1'b0); chk("f4_pv_count", 32'(pv_cnt - c0), 32'd8);

    // sof in the DONE cycle: back-to-back frames, no gap.
    c0 = pv_cnt; send_frame(32, 1, 1'b0); send_frame(32, 2, 1'b0);
    chk("b2b_pv_count", 32'(pv_cnt - c0), 32'd16);

    // Reset at pixel 12, with a sof competing in the same cycle.
    send_frame(12, 1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 10'h3ff);
    chk("rst_outputs_zero", 32'({o_prev_valid, o_frame_done, o_sync_err, o_prev_data, o_cur_data}), 32'd0);
    c0 = pv_cnt; send_frame(32, 2, 1'b0); chk("post_rst_f1_pv_count", 32'(pv_cnt - c0), 32'd0);
    c0 = pv_cnt; send_frame(32, 2, 1'b0); chk("post_rst_f2_pv_count", 32'(pv_cnt - c0), 32'd8);

    // Random traffic with occasional sof and rare reset.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 49) == 0, W'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
